alu_share_arb: RTL and testbench

Arbiter that shares the single modular ALU (FA/MUL/INV) and its operand/result RAM ports between two sequencers: requester 0 is the point-multiplication engine and requester 1 is the r/s/inverse controller. A requester holds ownership for a whole multi-operation sequence. The arbiter muxes the owner's ALU and RAM controls onto the shared ports, routes result-valid back to the owner only, tracks the one outstanding ALU operation, and flags protocol violations. It sits between the two sequencers and the ALU/RAM in the ECDSA core.

---
 rtl/alu_share_arb_pkg.sv | 21 ++
 rtl/alu_share_arb_rr2.sv | 14 +
 rtl/alu_share_arb.sv | 167 ++++++++++++++++
 tb/tb_alu_share_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arb_pkg.sv
// rtl/alu_share_arb_pkg.sv - shared constants and state encoding for the ALU share arbiter
package alu_share_arb_pkg;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 5;

    localparam logic [1:0] OP_FA  = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_INV = 2'b10;

    localparam int RAM_BLNK   = 31;
    localparam int RAM_ZRRAM  = 18;
    localparam int RAM_ONERAM = 19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN   = 2'b01,
        ST_DRAIN = 2'b10
    } arb_state_e;

endpackage

// File: rtl/alu_share_arb_rr2.sv
// rtl/alu_share_arb_rr2.sv - two-input round-robin picker
module arb_rr2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_pick,
    output logic o_valid
);

    // On a tie the requester opposite to the last winner is chosen
    assign o_valid = i_req0 | i_req1;
    assign o_pick  = (i_req0 & i_req1) ? ~i_last : i_req1;

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - shares the modular ALU and its RAM ports between two sequencers
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int WID  = DATA_W,
    parameter int AWID = ADDR_W,
    parameter int BLNK = RAM_BLNK
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req0,
    input  logic            i_req1,
    output logic            o_gnt0,
    output logic            o_gnt1,
    input  logic            i_aen0,
    input  logic            i_aen1,
    input  logic [1:0]      i_aop0,
    input  logic [1:0]      i_aop1,
    input  logic [AWID-1:0] i_ramra0,
    input  logic [AWID-1:0] i_ramra1,
    input  logic [AWID-1:0] i_ramwa0,
    input  logic [AWID-1:0] i_ramwa1,
    input  logic [WID-1:0]  i_ramwd0,
    input  logic [WID-1:0]  i_ramwd1,
    input  logic            i_ramwe0,
    input  logic            i_ramwe1,
    output logic            o_adivld0,
    output logic            o_adivld1,
    output logic            o_aen,
    output logic [1:0]      o_aop,
    output logic [AWID-1:0] o_ramra,
    output logic [AWID-1:0] o_ramwa,
    output logic [WID-1:0]  o_ramwd,
    output logic            o_ramwe,
    input  logic            i_adivld,
    output logic            o_err
);

    localparam logic [AWID-1:0] W_BLNK = AWID'(BLNK);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_own;
    logic       r_last;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_busy;
    logic       r_err;

    logic       w_own_nxt;
    logic       w_last_nxt;
    logic       w_pick;
    logic       w_pick_vld;
    logic       w_req_own;
    logic       w_own_aen;
    logic       w_aen_fwd;
    logic       w_busy_nxt;
    logic       w_err_set;

    arb_rr2 u_rr (
        .i_req0  (i_req0),
        .i_req1  (i_req1),
        .i_last  (r_last),
        .o_pick  (w_pick),
        .o_valid (w_pick_vld)
    );

    assign w_req_own = r_own ? i_req1 : i_req0;

    // State register: arbitration state, owner, round-robin history and registered grants
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_own   <= 1'b0;
            r_last  <= 1'b1;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_own   <= w_own_nxt;
            r_last  <= w_last_nxt;
            r_gnt0  <= (w_state_nxt == ST_OWN) & ~w_own_nxt;
            r_gnt1  <= (w_state_nxt == ST_OWN) &  w_own_nxt;
        end
    end

    // Next-state: grant from IDLE, release or drain when the owner drops its request
    always_comb begin
        w_state_nxt = r_state;
        w_own_nxt   = r_own;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_OWN;
                    w_own_nxt   = w_pick;
                    w_last_nxt  = w_pick;
                end
            end
            ST_OWN: begin
                if (!w_req_own) begin
                    w_state_nxt = r_busy ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (i_adivld) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: mux the granted requester onto the shared ports, idle values otherwise
    always_comb begin
        w_own_aen = 1'b0;
        o_aop     = OP_FA;
        o_ramra   = '0;
        o_ramwa   = W_BLNK;
        o_ramwd   = '0;
        o_ramwe   = 1'b0;
        if (r_gnt0) begin
            w_own_aen = i_aen0;
            o_aop     = i_aop0;
            o_ramra   = i_ramra0;
            o_ramwa   = i_ramwa0;
            o_ramwd   = i_ramwd0;
            o_ramwe   = i_ramwe0;
        end else if (r_gnt1) begin
            w_own_aen = i_aen1;
            o_aop     = i_aop1;
            o_ramra   = i_ramra1;
            o_ramwa   = i_ramwa1;
            o_ramwd   = i_ramwd1;
            o_ramwe   = i_ramwe1;
        end
        // a start is only accepted when the ALU is free or finishing this very cycle
        w_aen_fwd = w_own_aen & (~r_busy | i_adivld);
        o_aen     = w_aen_fwd;
    end

    assign o_gnt0    = r_gnt0;
    assign o_gnt1    = r_gnt1;
    // results go to whoever owned the ALU when the operation was issued, even while draining
    assign o_adivld0 = i_adivld & r_busy & ~r_own;
    assign o_adivld1 = i_adivld & r_busy &  r_own;
    assign o_err     = r_err;

    assign w_busy_nxt = w_aen_fwd ? 1'b1 : (i_adivld ? 1'b0 : r_busy);

    assign w_err_set = (i_aen0   & ~r_gnt0) | (i_aen1   & ~r_gnt1)
                     | (i_ramwe0 & ~r_gnt0) | (i_ramwe1 & ~r_gnt1)
                     | (w_own_aen & r_busy & ~i_adivld)
                     | (i_adivld & ~r_busy);

    // Outstanding-operation tracker and sticky protocol-error flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_err  <= r_err | w_err_set;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - randomized and directed bench for alu_share_arb against a behavioural model
module tb_alu_share_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req[2];
    logic         aen[2];
    logic [1:0]   aop[2];
    logic [4:0]   ramra[2];
    logic [4:0]   ramwa[2];
    logic [255:0] ramwd[2];
    logic         ramwe[2];
    logic         adivld;

    logic         gnt0, gnt1, adv0, adv1, s_aen, s_ramwe, err;
    logic [1:0]   s_aop;
    logic [4:0]   s_ramra, s_ramwa;
    logic [255:0] s_ramwd;

    int n_checks = 0;
    int n_errors = 0;

    // model: who holds the grant (-1 none), issuer of the outstanding op, draining flag
    int m_owner;
    int m_route;
    bit m_drain;
    bit m_busy;
    bit m_err;
    int m_last;

    always #5 clk = ~clk;

    alu_share_arb dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req0    (req[0]),
        .i_req1    (req[1]),
        .o_gnt0    (gnt0),
        .o_gnt1    (gnt1),
        .i_aen0    (aen[0]),
        .i_aen1    (aen[1]),
        .i_aop0    (aop[0]),
        .i_aop1    (aop[1]),
        .i_ramra0  (ramra[0]),
        .i_ramra1  (ramra[1]),
        .i_ramwa0  (ramwa[0]),
        .i_ramwa1  (ramwa[1]),
        .i_ramwd0  (ramwd[0]),
        .i_ramwd1  (ramwd[1]),
        .i_ramwe0  (ramwe[0]),
        .i_ramwe1  (ramwe[1]),
        .o_adivld0 (adv0),
        .o_adivld1 (adv1),
        .o_aen     (s_aen),
        .o_aop     (s_aop),
        .o_ramra   (s_ramra),
        .o_ramwa   (s_ramwa),
        .o_ramwd   (s_ramwd),
        .o_ramwe   (s_ramwe),
        .i_adivld  (adivld),
        .o_err     (err)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            req[i] = 0; aen[i] = 0; aop[i] = 0; ramra[i] = 0;
            ramwa[i] = 0; ramwd[i] = 0; ramwe[i] = 0;
        end
        adivld = 0;
    endtask

    task automatic model_reset();
        m_owner = -1; m_route = 0; m_drain = 0; m_busy = 0; m_err = 0; m_last = 1;
    endtask

    task automatic check_outputs();
        int  gi;
        bit  g;
        bit  e_aen;
        g  = (m_owner >= 0);
        gi = g ? m_owner : 0;
        e_aen = g && aen[gi] && (!m_busy || adivld);
        chk("gnt0",    gnt0,    m_owner == 0);
        chk("gnt1",    gnt1,    m_owner == 1);
        chk("aen",     s_aen,   e_aen);
        chk("aop",     s_aop,   g ? aop[gi]   : 2'b00);
        chk("ramra",   s_ramra, g ? ramra[gi] : 5'd0);
        chk("ramwa",   s_ramwa, g ? ramwa[gi] : 5'd31);
        chk("ramwd",   s_ramwd, g ? ramwd[gi] : 256'd0);
        chk("ramwe",   s_ramwe, g ? ramwe[gi] : 1'b0);
        chk("adivld0", adv0,    adivld && m_busy && m_route == 0);
        chk("adivld1", adv1,    adivld && m_busy && m_route == 1);
        chk("err",     err,     m_err);
    endtask

    task automatic model_update();
        int  gi;
        bit  g;
        bit  accepted;
        bit  bad;
        g  = (m_owner >= 0);
        gi = g ? m_owner : 0;
        accepted = g && aen[gi] && (!m_busy || adivld);
        bad = (aen[0] && m_owner != 0) || (aen[1] && m_owner != 1)
           || (ramwe[0] && m_owner != 0) || (ramwe[1] && m_owner != 1)
           || (g && aen[gi] && m_busy && !adivld)
           || (adivld && !m_busy);
        if (g) begin
            if (!req[gi]) begin
                m_drain = m_busy;
                m_owner = -1;
            end
        end else if (m_drain) begin
            if (adivld) m_drain = 0;
        end else if (req[0] || req[1]) begin
            m_owner = (req[0] && req[1]) ? 1 - m_last : (req[0] ? 0 : 1);
            m_route = m_owner;
            m_last  = m_owner;
        end
        if (accepted) m_busy = 1;
        else if (adivld) m_busy = 0;
        if (bad) m_err = 1;
    endtask

    // one clock: compare mid-cycle, then advance the model on the edge; returns just after the edge
    task automatic cyc();
        @(negedge clk);
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 0;
        #2;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_ramwa", s_ramwa, 5'd31);
        do_reset();
        chk("rst_err", err, 0);

        // single request: grant latency, same-cycle forwarding, routing
        cyc(); cyc();
        req[0] = 1;
        cyc();
        chk("t1_gnt0", gnt0, 1);
        cyc();
        aen[0] = 1; aop[0] = 2'b01;
        #1;
        chk("t1_aen", s_aen, 1);
        chk("t1_aop", s_aop, 2'b01);
        cyc();
        aen[0] = 0;
        repeat (6) cyc();
        adivld = 1;
        #1;
        chk("t1_adv0", adv0, 1);
        chk("t1_adv1", adv1, 0);
        cyc();
        adivld = 0;
        chk("t1_err", err, 0);

        // tie after reset goes to requester 0; dead cycle before requester 1
        do_reset();
        cyc(); cyc();
        req[0] = 1; req[1] = 1;
        cyc();
        chk("t2_gnt0", gnt0, 1);
        repeat (4) cyc();
        req[0] = 0;
        cyc();
        chk("t2_dead0", gnt0, 0);
        chk("t2_dead1", gnt1, 0);
        cyc();
        chk("t2_gnt1", gnt1, 1);

        // drain: owner 1 drops request while busy, requester 0 waits
        aen[1] = 1;
        cyc();
        aen[1] = 0; req[0] = 1; req[1] = 0;
        cyc();
        chk("t3_drain_gnt1", gnt1, 0);
        repeat (5) cyc();
        chk("t3_wait_gnt0", gnt0, 0);
        adivld = 1;
        #1;
        chk("t3_adv1", adv1, 1);
        cyc();
        adivld = 0;
        chk("t3_idle_gnt0", gnt0, 0);
        cyc();
        chk("t3_gnt0", gnt0, 1);

        // non-owner write is blocked and flags err
        ramwa[0] = 5'd7; ramwe[1] = 1; ramwa[1] = 5'd13;
        #1;
        chk("t4_ramwe", s_ramwe, 0);
        chk("t4_ramwa", s_ramwa, 5'd7);
        cyc();
        ramwe[1] = 0;
        chk("t4_err", err, 1);
        cyc();
        chk("t4_err_sticky", err, 1);

        // second start while busy is swallowed
        do_reset();
        req[0] = 1;
        cyc();
        aen[0] = 1;
        cyc();
        #1;
        chk("t5_aen_dup", s_aen, 0);
        cyc();
        aen[0] = 0;
        chk("t5_err", err, 1);

        // spurious result in IDLE
        do_reset();
        adivld = 1;
        #1;
        chk("t5_sp_adv0", adv0, 0);
        chk("t5_sp_adv1", adv1, 0);
        cyc();
        adivld = 0;
        chk("t5_sp_err", err, 1);

        // asynchronous reset mid-operation
        do_reset();
        req[0] = 1;
        cyc();
        aen[0] = 1; ramwe[0] = 1;
        #1;
        chk("t6_aen_pre", s_aen, 1);
        rst_n = 0;
        #1;
        chk("t6_gnt0", gnt0, 0);
        chk("t6_aen", s_aen, 0);
        chk("t6_ramwe", s_ramwe, 0);
        model_reset();
        aen[0] = 0; ramwe[0] = 0;
        #1;
        rst_n = 1;
        cyc();
        chk("t6_regnt", gnt0, 1);

        // randomized traffic against the model, with periodic resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 499) do_reset();
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(15) == 0) req[i] = ~req[i];
                aen[i]   = (m_owner == i) ? ($urandom_range(3) == 0) : ($urandom_range(63) == 0);
                aop[i]   = 2'($urandom_range(2));
                ramra[i] = 5'($urandom);
                ramwa[i] = 5'($urandom);
                ramwd[i] = {8{$urandom}};
                ramwe[i] = (m_owner == i) ? ($urandom_range(1) == 0) : ($urandom_range(63) == 0);
            end
            adivld = m_busy ? ($urandom_range(3) == 0) : ($urandom_range(31) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
